// File: rtl/unfolded_not_pipelined.sv
// AES-128 encryption core, fully unfolded: key expansion and all rounds form one combinational path.
// Only Cipher_o is registered. Define AES_INPUT_REG_EN to also register key_i/text_i (2-clock latency).
module unfolded_not_pipelined #(
    parameter int NR = 10
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic [127:0] key_i,
    input  logic [127:0] text_i,
    output logic [127:0] Cipher_o
);

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] s;
        case (b)
            8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b;
            8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
            8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b;
            8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
            8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d;
            8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
            8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf;
            8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
            8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26;
            8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
            8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1;
            8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
            8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3;
            8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
            8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2;
            8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
            8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a;
            8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
            8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3;
            8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
            8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed;
            8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
            8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39;
            8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
            8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb;
            8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
            8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f;
            8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
            8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f;
            8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
            8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21;
            8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
            8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec;
            8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
            8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d;
            8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
            8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc;
            8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
            8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14;
            8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
            8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a;
            8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
            8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62;
            8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
            8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d;
            8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
            8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea;
            8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
            8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e;
            8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
            8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f;
            8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
            8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66;
            8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
            8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9;
            8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
            8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11;
            8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
            8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9;
            8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
            8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d;
            8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
            8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f;
            8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] round);
        logic [7:0] rc;
        case (round)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // Multiply by x in GF(2^8), reducing by 0x11b.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 4; i++) begin
            o[32*i +: 32] = sub_word(s[32*i +: 32]);
        end
        return o;
    endfunction

    // Byte n sits at bits [127-8n -: 8]; byte (row r, column c) is n = 4c + r.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 4; i++) begin
            o[32*i +: 32] = mix_column(s[32*i +: 32]);
        end
        return o;
    endfunction

    function automatic logic [127:0] next_round_key(input logic [127:0] prev, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = sub_word({prev[23:0], prev[31:24]}) ^ {rc, 24'h0};
        w0 = prev[127:96] ^ t;
        w1 = prev[95:64] ^ w0;
        w2 = prev[63:32] ^ w1;
        w3 = prev[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    logic [127:0] core_key;
    logic [127:0] core_text;
    logic [127:0] round_key;
    logic [127:0] round_state;
    logic [127:0] cipher_comb;

`ifdef AES_INPUT_REG_EN
    logic [127:0] key_q;
    logic [127:0] text_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            key_q  <= '0;
            text_q <= '0;
        end else begin
            key_q  <= key_i;
            text_q <= text_i;
        end
    end

    assign core_key  = key_q;
    assign core_text = text_q;
`else
    assign core_key  = key_i;
    assign core_text = text_i;
`endif

    // Round keys are produced alongside the rounds so only one key is live at a time.
    always_comb begin
        round_key   = core_key;
        round_state = core_text ^ core_key;
        for (int r = 1; r <= NR; r++) begin
            round_key = next_round_key(round_key, rcon(r[3:0]));
            if (r == NR) begin
                round_state = shift_rows(sub_bytes(round_state)) ^ round_key;
            end else begin
                round_state = mix_columns(shift_rows(sub_bytes(round_state))) ^ round_key;
            end
        end
        cipher_comb = round_state;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            Cipher_o <= '0;
        end else begin
            Cipher_o <= cipher_comb;
        end
    end

endmodule

// File: tb/tb_unfolded_not_pipelined.sv
// Self-checking bench for unfolded_not_pipelined: a byte-array AES-128 model checked every cycle,
// plus FIPS-197 literal vectors. Honours AES_INPUT_REG_EN for the 2-clock latency build.
module tb_unfolded_not_pipelined;

    logic         clk_i;
    logic         rstn_i;
    logic [127:0] key_i;
    logic [127:0] text_i;
    logic [127:0] Cipher_o;

    int checks = 0;
    int errors = 0;

`ifdef AES_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    localparam logic [127:0] KEY_C1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] TXT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] TXT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B    = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] CT_ZERO = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    unfolded_not_pipelined #(.NR(10)) dut (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .key_i    (key_i),
        .text_i   (text_i),
        .Cipher_o (Cipher_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #10 clk_i = ~clk_i;
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box derived from its definition: multiplicative inverse followed by the affine map.
    logic [7:0] sbox_tab [256];
    initial begin
        for (int i = 0; i < 256; i++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int j = 1; j < 256; j++) begin
                if (gmul(8'(i), 8'(j)) == 8'h01) inv = 8'(j);
            end
            sbox_tab[i] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                          {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    end

    function automatic logic [127:0] aes_model(input logic [127:0] key, input logic [127:0] text);
        logic [31:0]  w [44];
        logic [7:0]   st [16];
        logic [7:0]   tmp [16];
        logic [7:0]   a [4];
        logic [7:0]   rc;
        logic [31:0]  t;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 16; i++) st[i] = text[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) st[i] = sbox_tab[st[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    tmp[4*c + row] = st[4*((c + row) % 4) + row];
            for (int c = 0; c < 4; c++) begin
                for (int row = 0; row < 4; row++) a[row] = tmp[4*c + row];
                for (int row = 0; row < 4; row++) begin
                    if (r < 10)
                        st[4*c + row] = gmul(a[row], 8'h02) ^ gmul(a[(row+1)%4], 8'h03) ^
                                        a[(row+2)%4] ^ a[(row+3)%4];
                    else
                        st[4*c + row] = a[row];
                end
            end
            for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[4*r + i/4][31 - 8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = st[i];
        return res;
    endfunction

    task automatic check_output(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    // Expected Cipher_o, advanced at every active edge and cleared by reset.
    logic [127:0] exp_out;
    logic [127:0] model_key_q;
    logic [127:0] model_text_q;
    initial begin
        exp_out      = '0;
        model_key_q  = '0;
        model_text_q = '0;
        forever begin
            @(posedge clk_i or negedge rstn_i);
            if (!rstn_i) begin
                exp_out      = '0;
                model_key_q  = '0;
                model_text_q = '0;
            end else begin
`ifdef AES_INPUT_REG_EN
                exp_out      = aes_model(model_key_q, model_text_q);
                model_key_q  = key_i;
                model_text_q = text_i;
`else
                exp_out = aes_model(key_i, text_i);
`endif
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_i);
            check_output("cycle_compare", Cipher_o, exp_out);
        end
    end

    // Output must not move when inputs change between edges.
    logic watch_en = 1'b0;
    initial begin
        forever begin
            @(key_i or text_i);
            if (watch_en) begin
                #2;
                check_output("mid_cycle_hold", Cipher_o, exp_out);
            end
        end
    end

    task automatic wait_slot();
        @(posedge clk_i);
        #5;
    endtask

    task automatic apply_stimulus(input logic [127:0] key, input logic [127:0] text,
                                  input logic [127:0] want, input string name);
        key_i  = key;
        text_i = text;
        repeat (LAT) @(posedge clk_i);
        #5;
        check_output(name, Cipher_o, want);
    endtask

    task automatic release_reset(input logic [127:0] key, input logic [127:0] text,
                                 input logic [127:0] want, input string name);
        key_i  = key;
        text_i = text;
        rstn_i = 1'b1;
`ifdef AES_INPUT_REG_EN
        wait_slot();
        check_output("first_after_reset", Cipher_o, CT_ZERO);
        @(posedge clk_i);
        #5;
`else
        wait_slot();
`endif
        check_output(name, Cipher_o, want);
    endtask

    initial begin
        rstn_i = 1'b1;
        key_i  = 128'hdeadbeef_01234567_89abcdef_cafef00d;
        text_i = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
        #2;
        rstn_i = 1'b0;
        #1;
        check_output("model_sbox_00", {120'h0, sbox_tab[8'h00]}, 128'h63);
        check_output("model_sbox_53", {120'h0, sbox_tab[8'h53]}, 128'hed);
        check_output("model_c1", aes_model(KEY_C1, TXT_C1), CT_C1);
        check_output("model_appb", aes_model(KEY_B, TXT_B), CT_B);
        check_output("model_zero", aes_model(128'h0, 128'h0), CT_ZERO);

        repeat (3) @(posedge clk_i);
        #5;
        check_output("reset_held", Cipher_o, 128'h0);

        release_reset(KEY_C1, TXT_C1, CT_C1, "fips_c1");
        wait_slot();
        apply_stimulus(KEY_B, TXT_B, CT_B, "fips_appb");
        wait_slot();
        apply_stimulus(128'h0, 128'h0, CT_ZERO, "all_zero");

        wait_slot();
        rstn_i = 1'b0;
        #1;
        check_output("async_reset", Cipher_o, 128'h0);
        wait_slot();
        check_output("reset_low_edge", Cipher_o, 128'h0);
        release_reset(KEY_B, TXT_B, CT_B, "appb_after_reset");

        wait_slot();
        watch_en = 1'b1;
        key_i  = 128'he01fc9945862fdd9cba66f451f0621e3;
        text_i = 128'h004e7d60cde97ae9d3ebf5271779482e;
        #50;
        text_i = 128'h3b9b8471706b8bd276eb16d03798ed0e;
        #50;
        text_i = 128'hec9b152395cbac6fdffaf89228275eb4;
        repeat (LAT + 1) @(posedge clk_i);
        #5;
        check_output("stream_last", Cipher_o,
                     aes_model(128'he01fc9945862fdd9cba66f451f0621e3,
                               128'hec9b152395cbac6fdffaf89228275eb4));
        watch_en = 1'b0;
        repeat (2) @(posedge clk_i);
        #5;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
